// File: rtl/cp0_defs.sv
// Shared CP0 definitions: register numbers, field positions, exception codes.
package cp0_defs;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned INT_W  = 6;
    localparam int unsigned EXC_W  = 5;

    localparam logic [ADDR_W-1:0] REG_SR    = 5'd12;
    localparam logic [ADDR_W-1:0] REG_CAUSE = 5'd13;
    localparam logic [ADDR_W-1:0] REG_EPC   = 5'd14;
    localparam logic [ADDR_W-1:0] REG_PRID  = 5'd15;

    localparam int unsigned SR_IM_LO    = 10;
    localparam int unsigned SR_IM_HI    = 15;
    localparam int unsigned SR_EXL      = 1;
    localparam int unsigned SR_IE       = 0;
    localparam int unsigned CAUSE_BD    = 31;
    localparam int unsigned CAUSE_IP_LO = 10;
    localparam int unsigned CAUSE_IP_HI = 15;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;

    localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

    localparam logic [DATA_W-1:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0_unit.sv
// CP0: SR/Cause/EPC/PrID, interrupt vs. exception arbitration, eret handling.
module cp0_unit
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h2020_0707,
    parameter logic [31:0] EPC_MASK   = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out
);

    logic [INT_W-1:0]  sr_im;
    logic              sr_exl;
    logic              sr_ie;
    logic              cause_bd;
    logic [INT_W-1:0]  cause_ip;
    logic [EXC_W-1:0]  cause_exc;
    logic [DATA_W-1:0] epc;

    logic              int_pend;
    logic              exc_pend;
    logic [DATA_W-1:0] victim_pc;

    // Arbitration uses the registered SR, so an mtc0 only affects the next cycle.
    assign int_pend  = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
    assign exc_pend  = (exc_code != EXC_INT) & ~sr_exl;
    assign req       = int_pend | exc_pend;
    assign victim_pc = bd ? (pc - 32'd4) : pc;
    assign epc_out   = epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hw_int;
            if (req) begin
                // Exception entry overrides any concurrent mtc0 or eret.
                sr_exl    <= 1'b1;
                cause_bd  <= bd;
                cause_exc <= int_pend ? EXC_INT : exc_code;
                epc       <= victim_pc & EPC_MASK;
            end else begin
                if (we && addr == REG_SR) begin
                    sr_im  <= wdata[SR_IM_HI:SR_IM_LO];
                    sr_exl <= wdata[SR_EXL];
                    sr_ie  <= wdata[SR_IE];
                end
                if (we && addr == REG_EPC) begin
                    epc <= wdata & EPC_MASK;
                end
                if (eret) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    // Read mux; unimplemented bits and registers read as zero.
    always_comb begin
        rdata = '0;
        case (addr)
            REG_SR: begin
                rdata[SR_IM_HI:SR_IM_LO] = sr_im;
                rdata[SR_EXL]            = sr_exl;
                rdata[SR_IE]             = sr_ie;
            end
            REG_CAUSE: begin
                rdata[CAUSE_BD]                  = cause_bd;
                rdata[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip;
                rdata[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
            end
            REG_EPC:  rdata = epc;
            REG_PRID: rdata = PRID_VALUE;
            default:  rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cp0_unit dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .we       (we),
        .wdata    (wdata),
        .rdata    (rdata),
        .pc       (pc),
        .bd       (bd),
        .exc_code (exc_code),
        .hw_int   (hw_int),
        .eret     (eret),
        .req      (req),
        .epc_out  (epc_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr = '0; we = 1'b0; wdata = '0; pc = '0; bd = 1'b0;
        exc_code = '0; hw_int = '0; eret = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_epc_out", epc_out, 32'd0);
        rd("rst_sr", 5'd12, 32'd0);
        rd("rst_cause", 5'd13, 32'd0);
        rd("rst_epc", 5'd14, 32'd0);

        // Interrupt entry
        wr(5'd12, 32'h0000_0401);
        rd("sr_write", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001; pc = 32'h0000_3010; bd = 1'b0;
        #1;
        check("int_req", {31'd0, req}, 32'd1);
        tick();
        check("int_epc", epc_out, 32'h0000_3010);
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_sr_exl", 5'd12, 32'h0000_0403);
        check("int_req_off", {31'd0, req}, 32'd0);

        // EXL blocks everything until eret
        exc_code = 5'd4;
        #1;
        check("exl_block", {31'd0, req}, 32'd0);
        eret = 1'b1;
        tick();
        eret = 1'b0; exc_code = 5'd0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        check("eret_rereq", {31'd0, req}, 32'd1);
        tick();

        // Exception in a delay slot with interrupts disabled
        hw_int = 6'b0; eret = 1'b1;
        tick();
        eret = 1'b0;
        wr(5'd12, 32'h0000_0400);
        exc_code = 5'd12; pc = 32'h0000_3020; bd = 1'b1;
        #1;
        check("ov_req", {31'd0, req}, 32'd1);
        tick();
        exc_code = 5'd0; bd = 1'b0;
        check("ov_epc", epc_out, 32'h0000_301C);
        rd("ov_cause", 5'd13, 32'h8000_0030);

        // Interrupt beats exception, mtc0 EPC dropped
        eret = 1'b1;
        tick();
        eret = 1'b0;
        wr(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; exc_code = 5'd10; pc = 32'h0000_3043; bd = 1'b0;
        addr = 5'd14; wdata = 32'hDEAD_BEE0; we = 1'b1;
        #1;
        check("pri_req", {31'd0, req}, 32'd1);
        tick();
        we = 1'b0; exc_code = 5'd0;
        check("pri_epc", epc_out, 32'h0000_3040);
        rd("pri_cause", 5'd13, 32'h0000_0400);

        // EPC masking, PrID, Cause read-only, SR unimplemented bits
        hw_int = 6'b100000;
        wr(5'd14, 32'h0000_3007);
        check("epc_mask", epc_out, 32'h0000_3004);
        rd("prid", 5'd15, 32'h2020_0707);
        rd("unmapped", 5'd3, 32'd0);
        wr(5'd13, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h0000_8000);
        wr(5'd12, 32'hFFFF_FFFF);
        rd("sr_bits", 5'd12, 32'h0000_FC03);
        check("exl_hold", {31'd0, req}, 32'd0);

        // Reset mid-handler
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst2_req", {31'd0, req}, 32'd0);
        rd("rst2_sr", 5'd12, 32'd0);
        rd("rst2_cause", 5'd13, 32'd0);
        rd("rst2_epc", 5'd14, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
